// File: rtl/nfa_stream_sequencer.sv
// nfa_stream_sequencer
//
// Runs one automaton tile over a bounded symbol stream, one job at a time.
// For each job it:
//   - holds the automaton in reset for RST_CYCLES cycles;
//   - streams symbols from a valid/ready source into the automaton;
//   - captures every non-zero report vector, tagged with the 0-based offset
//     of the symbol that produced it, into a first-word-fall-through FIFO.
// Symbol issue is throttled so that a report always finds room in the FIFO.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   start            job start pulse, honoured only in IDLE with an empty FIFO
//   stream_len       number of symbols in the job, sampled on accepted start
//   busy             high in FLUSH / RUN / DRAIN
//   done             one-cycle pulse on entering DONE
//   in_valid         upstream symbol valid
//   in_ready         symbol accepted when in_valid & in_ready
//   in_symbol        upstream symbol data
//   aut_reset        automaton reset
//   aut_run          automaton enable, one cycle per issued symbol
//   aut_symbol       symbol presented to the automaton
//   aut_report       automaton report vector, valid the cycle after aut_run
//   rpt_valid        report FIFO head valid
//   rpt_ready        downstream pop
//   rpt_vector       head report vector
//   rpt_offset       head symbol offset
//   rpt_count        reports pushed during the current job (saturating)
//
// State table
//   S_IDLE  | automaton held in reset, waiting for start
//   S_FLUSH | automaton reset held for RST_CYCLES cycles
//   S_RUN   | symbols issued to the automaton
//   S_DRAIN | all symbols issued, waiting for the last reports to be sampled
//   S_DONE  | one-cycle done pulse, then back to S_IDLE

module nfa_stream_sequencer #(
  parameter int NUM_REPORTS = 4,
  parameter int SYM_W       = 8,
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int RST_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       stream_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       in_symbol,
  output logic                   aut_reset,
  output logic                   aut_run,
  output logic [SYM_W-1:0]       aut_symbol,
  input  logic [NUM_REPORTS-1:0] aut_report,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [NUM_REPORTS-1:0] rpt_vector,
  output logic [CNT_W-1:0]       rpt_offset,
  output logic [CNT_W-1:0]       rpt_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int FL_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [OCC_W:0]   DEPTH_RES  = (OCC_W + 1)'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(FIFO_DEPTH);
  localparam logic [FL_W-1:0]  FLUSH_INIT = FL_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued;
  logic [FL_W-1:0]  flush_cnt;

  // Offset pipeline: run_off belongs to the symbol on aut_run this cycle,
  // smp_off to the symbol whose report is on aut_report this cycle.
  logic [CNT_W-1:0] run_off;
  logic [CNT_W-1:0] smp_off;
  logic             inflight;

  logic [NUM_REPORTS-1:0] fifo_vec [FIFO_DEPTH];
  logic [CNT_W-1:0]       fifo_off [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       fifo_count;

  logic           accept;
  logic           handshake;
  logic           push;
  logic           push_ok;
  logic           pop;
  logic           fifo_full;
  logic [OCC_W:0] reserved;

  assign accept    = (state == S_IDLE) && start && (fifo_count == '0);
  assign fifo_full = (fifo_count == DEPTH_OCC);

  // Each symbol in the automaton pipeline (aut_run stage and sample stage)
  // may still produce a report, so both count against free FIFO space.
  assign reserved = {1'b0, fifo_count}
                  + (OCC_W + 1)'(aut_run)
                  + (OCC_W + 1)'(inflight);

  // in_ready is decoded from registers only; registering it would cost a
  // bubble after every handshake because the throttle changes each cycle.
  assign in_ready  = (state == S_RUN) && (issued < len_q) && (reserved < DEPTH_RES);
  assign handshake = in_valid && in_ready;

  assign push    = inflight && (aut_report != '0);
  assign pop     = rpt_valid && rpt_ready;
  // The throttle already rules out a push into a full FIFO without a pop;
  // the guard keeps the FIFO state consistent regardless.
  assign push_ok = push && (!fifo_full || pop);

  assign rpt_valid  = (fifo_count != '0);
  assign rpt_vector = rpt_valid ? fifo_vec[rd_ptr] : '0;
  assign rpt_offset = rpt_valid ? fifo_off[rd_ptr] : '0;

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      aut_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      aut_run    <= 1'b0;
      aut_symbol <= '0;
      len_q      <= '0;
      issued     <= '0;
      flush_cnt  <= '0;
      run_off    <= '0;
    end else begin
      done    <= 1'b0;
      aut_run <= 1'b0;
      case (state)
        S_IDLE: begin
          aut_reset <= 1'b1;
          if (accept) begin
            len_q     <= stream_len;
            issued    <= '0;
            run_off   <= '0;
            flush_cnt <= FLUSH_INIT;
            busy      <= 1'b1;
            state     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            aut_reset <= 1'b0;
            state     <= (len_q == '0) ? S_DRAIN : S_RUN;
          end else begin
            flush_cnt <= flush_cnt - FL_W'(1);
          end
        end
        S_RUN: begin
          if (handshake) begin
            aut_symbol <= in_symbol;
            aut_run    <= 1'b1;
            run_off    <= issued;
            issued     <= issued + CNT_W'(1);
            if (issued + CNT_W'(1) == len_q) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Wait until the last issued symbol has had its report sampled.
          if (!aut_run && !inflight) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          aut_reset <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          aut_reset <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Report sample tracking: the automaton answers one cycle after aut_run.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      smp_off  <= '0;
    end else if (accept) begin
      inflight <= 1'b0;
      smp_off  <= '0;
    end else begin
      inflight <= aut_run;
      smp_off  <= run_off;
    end
  end

  // Report FIFO storage; pointers wrap naturally for a power-of-two depth.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_vec[wr_ptr] <= aut_report;
      fifo_off[wr_ptr] <= smp_off;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rpt_count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (accept) begin
        rpt_count <= '0;
      end else if (push_ok && (rpt_count != '1)) begin
        rpt_count <= rpt_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nfa_stream_sequencer.sv
// Self-checking bench for nfa_stream_sequencer. The bench plays both the
// symbol source and the automaton: the automaton answers each aut_run with a
// report taken from a per-offset table, and a queue model of the report FIFO
// predicts every popped entry.
module tb_nfa_stream_sequencer;
  localparam int NR    = 4;
  localparam int SW    = 8;
  localparam int CW    = 32;
  localparam int DEPTH = 8;
  localparam int RST   = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] stream_len;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_symbol;
  logic          aut_reset;
  logic          aut_run;
  logic [SW-1:0] aut_symbol;
  logic [NR-1:0] aut_report;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [NR-1:0] rpt_vector;
  logic [CW-1:0] rpt_offset;
  logic [CW-1:0] rpt_count;

  nfa_stream_sequencer #(
    .NUM_REPORTS(NR), .SYM_W(SW), .CNT_W(CW), .FIFO_DEPTH(DEPTH), .RST_CYCLES(RST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stream_len(stream_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_symbol(in_symbol), .aut_reset(aut_reset), .aut_run(aut_run),
    .aut_symbol(aut_symbol), .aut_report(aut_report), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_vector(rpt_vector), .rpt_offset(rpt_offset),
    .rpt_count(rpt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NR-1:0] v;
    int            off;
  } rpt_t;

  rpt_t          q[$];
  logic [SW-1:0] sym_tbl[64];
  logic [NR-1:0] rep_tbl[64];
  int            valid_mode, ready_mode;
  int            sym_idx, run_k, done_cnt, pop_cnt, push_cnt;
  logic [NR-1:0] next_rep;
  int            next_off, cur_off;
  bit            prev_hs;
  logic [SW-1:0] prev_sym;
  logic          s_aut_reset, s_busy, s_done, s_in_ready, s_rpt_valid;
  logic [CW-1:0] s_rpt_count;
  int            total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: observe at negedge, drive 1ns after posedge.
  task automatic tick();
    bit   hs, pop, push;
    rpt_t e;
    @(negedge clk);
    s_aut_reset = aut_reset;
    s_busy      = busy;
    s_done      = done;
    s_in_ready  = in_ready;
    s_rpt_valid = rpt_valid;
    s_rpt_count = rpt_count;
    if (reset) begin
      q.delete();
      prev_hs  = 1'b0;
      next_rep = '0;
    end else begin
      chk("aut_run", aut_run, prev_hs);
      if (aut_run) begin
        chk("aut_symbol", aut_symbol, prev_sym);
        next_rep = (run_k < 64) ? rep_tbl[run_k] : '0;
        next_off = run_k;
        run_k++;
      end else begin
        next_rep = '0;
      end
      hs = in_valid && in_ready;
      prev_hs = hs;
      if (hs) begin
        prev_sym = (sym_idx < 64) ? sym_tbl[sym_idx] : '0;
        sym_idx++;
      end
      chk("rpt_valid", rpt_valid, q.size() != 0);
      pop = rpt_valid && rpt_ready;
      if (rpt_valid && q.size() != 0) begin
        chk("rpt_vector", rpt_vector, q[0].v);
        chk("rpt_offset", rpt_offset, q[0].off);
      end
      push = (aut_report != '0);
      chk("no_overflow", (q.size() + int'(push) - int'(pop)) <= DEPTH, 1);
      if (pop && q.size() != 0) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      if (push) begin
        e.v   = aut_report;
        e.off = cur_off;
        q.push_back(e);
        push_cnt++;
      end
      if (done) done_cnt++;
    end
    @(posedge clk);
    #1;
    aut_report = next_rep;
    cur_off    = next_off;
    case (valid_mode)
      0:       in_valid = 1'b1;
      1:       in_valid = !in_valid;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_symbol = (sym_idx < 64) ? sym_tbl[sym_idx] : '0;
    case (ready_mode)
      0:       rpt_ready = 1'b0;
      1:       rpt_ready = 1'b1;
      default: rpt_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic begin_job(input int len);
    run_k    = 0;
    sym_idx  = 0;
    done_cnt = 0;
    pop_cnt  = 0;
    push_cnt = 0;
    start      = 1'b1;
    stream_len = CW'(len);
    tick();
    start = 1'b0;
    for (int i = 1; i <= RST + 1; i++) begin
      tick();
      chk("aut_reset_flush", s_aut_reset, i <= RST);
      if (i == 1) chk("busy_flush", s_busy, 1);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt, 1);
    tick();
    chk("done_one_cycle", s_done, 0);
    chk("busy_after_done", s_busy, 0);
  endtask

  task automatic end_job(input int len);
    chk("aut_run_count", run_k, len);
    chk("handshakes", sym_idx, len);
    chk("rpt_count", s_rpt_count, push_cnt);
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while ((q.size() != 0 || s_rpt_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_valid", s_rpt_valid, 0);
    chk("drain_model", q.size(), 0);
  endtask

  task automatic fill_syms();
    for (int i = 0; i < 64; i++) sym_tbl[i] = SW'($urandom_range(0, 255));
  endtask

  initial begin
    int len;
    int n;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; stream_len = '0;
    in_valid = 1'b0; in_symbol = '0; aut_report = '0; rpt_ready = 1'b0;
    valid_mode = 0; ready_mode = 1;
    next_rep = '0; next_off = 0; cur_off = 0; prev_hs = 1'b0; prev_sym = '0;
    sym_idx = 0; run_k = 0; done_cnt = 0; pop_cnt = 0; push_cnt = 0;
    for (int i = 0; i < 64; i++) begin sym_tbl[i] = '0; rep_tbl[i] = '0; end

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_aut_reset", s_aut_reset, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_in_ready", s_in_ready, 0);
    chk("rst_rpt_valid", s_rpt_valid, 0);
    chk("rst_rpt_count", s_rpt_count, 0);

    // Basic 4-symbol job, no reports.
    sym_tbl[0] = 8'h05; sym_tbl[1] = 8'h0A; sym_tbl[2] = 8'h20; sym_tbl[3] = 8'h30;
    begin_job(4);
    wait_done(50);
    end_job(4);
    chk("t1_no_reports", s_rpt_count, 0);
    drain();

    // Reports at offsets 1 and 3.
    rep_tbl[1] = 4'b0001; rep_tbl[3] = 4'b0001;
    begin_job(4);
    wait_done(50);
    end_job(4);
    chk("t2_rpt_count", s_rpt_count, 2);
    drain();
    chk("t2_pops", pop_cnt, 2);

    // FIFO fills with no downstream pops; issue must stall at the depth.
    for (int i = 0; i < 64; i++) rep_tbl[i] = 4'b1000;
    fill_syms();
    ready_mode = 0;
    begin_job(20);
    repeat (80) tick();
    chk("t3_fill_count", s_rpt_count, 8);
    chk("t3_in_ready_low", s_in_ready, 0);
    chk("t3_busy", s_busy, 1);
    chk("t3_rpt_valid", s_rpt_valid, 1);
    ready_mode = 1;
    wait_done(300);
    end_job(20);
    chk("t3_rpt_count", s_rpt_count, 20);
    drain();
    chk("t3_pops", pop_cnt, 20);

    // Toggling in_valid; start during RUN is ignored.
    valid_mode = 1;
    fill_syms();
    for (int i = 0; i < 64; i++) rep_tbl[i] = NR'($urandom_range(1, 15));
    begin_job(3);
    start = 1'b1; stream_len = 9;
    tick();
    start = 1'b0; stream_len = 3;
    wait_done(60);
    end_job(3);
    drain();
    chk("t4_pops", pop_cnt, 3);
    valid_mode = 0;

    // Empty job.
    begin_job(0);
    wait_done(20);
    end_job(0);
    chk("t5_rpt_count", s_rpt_count, 0);

    // Job ends with reports left; a start is ignored until the FIFO empties.
    for (int i = 0; i < 64; i++) rep_tbl[i] = 4'b0010;
    ready_mode = 0;
    begin_job(3);
    wait_done(60);
    end_job(3);
    start = 1'b1; stream_len = 2;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t6_start_ignored_busy", s_busy, 0);
    chk("t6_start_ignored_rst", s_aut_reset, 1);
    chk("t6_count_kept", s_rpt_count, 3);
    drain();
    chk("t6_pops", pop_cnt, 3);

    // Reset in the middle of a job.
    fill_syms();
    for (int i = 0; i < 64; i++) rep_tbl[i] = NR'($urandom_range(0, 15));
    begin_job(5);
    n = 0;
    while (sym_idx < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t7_two_issued", sym_idx, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t7_aut_reset", s_aut_reset, 1);
    chk("t7_busy", s_busy, 0);
    chk("t7_fifo_empty", s_rpt_valid, 0);
    chk("t7_rpt_count", s_rpt_count, 0);
    repeat (3) tick();
    chk("t7_no_done", done_cnt, 0);
    begin_job(1);
    wait_done(30);
    end_job(1);
    drain();

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      fill_syms();
      for (int i = 0; i < 64; i++)
        rep_tbl[i] = ($urandom_range(0, 1) != 0) ? NR'($urandom_range(1, 15)) : '0;
      valid_mode = 2;
      ready_mode = 2;
      len = $urandom_range(1, 24);
      begin_job(len);
      wait_done(600);
      end_job(len);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
